// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for a multi-channel PWM generator: once per period, one busy
// channel (round-robin) moves one step toward its target and the write is held.
module pwm_fade_ctrl #(
   parameter int PWM_WIDTH  = 16,
   parameter int NUM_PWM    = 4,
   parameter int STEP_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [$clog2(NUM_PWM)-1:0] cfg_chan,
   input  logic [PWM_WIDTH-1:0]       cfg_target,
   input  logic [STEP_WIDTH-1:0]      cfg_step,
   input  logic                       period_tick,
   output logic [PWM_WIDTH-1:0]       new_thres,
   output logic [$clog2(NUM_PWM)-1:0] sel_thres,
   output logic                       set_thres,
   output logic [NUM_PWM-1:0]         busy,
   output logic                       all_idle
);

   localparam int CW = $clog2(NUM_PWM);
   localparam int WX = PWM_WIDTH + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PICK = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic [PWM_WIDTH-1:0]  cur_q  [NUM_PWM];
   logic [PWM_WIDTH-1:0]  cur_d  [NUM_PWM];
   logic [PWM_WIDTH-1:0]  tgt_q  [NUM_PWM];
   logic [PWM_WIDTH-1:0]  tgt_d  [NUM_PWM];
   logic [STEP_WIDTH-1:0] step_q [NUM_PWM];
   logic [STEP_WIDTH-1:0] step_d [NUM_PWM];

   logic [1:0]           state_q, state_d;
   logic [CW-1:0]        ptr_q, ptr_d;
   logic [PWM_WIDTH-1:0] new_thres_q, new_thres_d;
   logic [CW-1:0]        sel_thres_q, sel_thres_d;
   logic                 set_thres_q, set_thres_d;
   logic [NUM_PWM-1:0]   busy_q, busy_d;
   logic                 all_idle_q, all_idle_d;
   logic                 cfg_ready_q, cfg_ready_d;

   logic                 found;
   logic [CW-1:0]        idx;
   logic [CW-1:0]        pick_idx;
   logic [PWM_WIDTH-1:0] nxt;

   // Difference is formed one bit wider so the clamp test can never wrap.
   function automatic logic [PWM_WIDTH-1:0] fade_next(
      input logic [PWM_WIDTH-1:0]  cur,
      input logic [PWM_WIDTH-1:0]  tgt,
      input logic [STEP_WIDTH-1:0] step
   );
      logic [WX-1:0] diff_x;
      logic          up;
      up     = cur < tgt;
      diff_x = up ? (WX'(tgt) - WX'(cur)) : (WX'(cur) - WX'(tgt));
      if (step == '0 || diff_x <= WX'(step))
         return tgt;
      else if (up)
         return cur + PWM_WIDTH'(step);
      else
         return cur - PWM_WIDTH'(step);
   endfunction

   always_comb begin
      cur_d       = cur_q;
      tgt_d       = tgt_q;
      step_d      = step_q;
      state_d     = state_q;
      ptr_d       = ptr_q;
      new_thres_d = new_thres_q;
      sel_thres_d = sel_thres_q;
      set_thres_d = set_thres_q;
      found       = 1'b0;
      idx         = '0;
      pick_idx    = '0;
      nxt         = '0;

      if (cfg_valid && cfg_ready_q) begin
         tgt_d[cfg_chan]  = cfg_target;
         step_d[cfg_chan] = cfg_step;
      end

      for (int unsigned i = 1; i <= NUM_PWM; i++) begin
         idx = ptr_q + CW'(i);
         if (!found && cur_q[idx] != tgt_q[idx]) begin
            found    = 1'b1;
            pick_idx = idx;
         end
      end
      nxt = fade_next(cur_q[pick_idx], tgt_q[pick_idx], step_q[pick_idx]);

      case (state_q)
         ST_IDLE: begin
            set_thres_d = 1'b0;
            if (period_tick) state_d = ST_PICK;
         end
         ST_HOLD: begin
            if (period_tick) state_d = ST_PICK;
         end
         ST_PICK: begin
            if (found) begin
               cur_d[pick_idx] = nxt;
               new_thres_d     = nxt;
               sel_thres_d     = pick_idx;
               set_thres_d     = 1'b1;
               ptr_d           = pick_idx;
               state_d         = ST_HOLD;
            end else begin
               set_thres_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      for (int unsigned c = 0; c < NUM_PWM; c++)
         busy_d[c] = cur_d[c] != tgt_d[c];
      all_idle_d  = ~|busy_d;
      cfg_ready_d = state_d != ST_PICK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_PWM; c++) begin
            cur_q[c]  <= '0;
            tgt_q[c]  <= '0;
            step_q[c] <= '0;
         end
         state_q     <= ST_IDLE;
         ptr_q       <= CW'(NUM_PWM - 1);
         new_thres_q <= '0;
         sel_thres_q <= '0;
         set_thres_q <= 1'b0;
         busy_q      <= '0;
         all_idle_q  <= 1'b1;
         cfg_ready_q <= 1'b0;
      end else begin
         cur_q       <= cur_d;
         tgt_q       <= tgt_d;
         step_q      <= step_d;
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         new_thres_q <= new_thres_d;
         sel_thres_q <= sel_thres_d;
         set_thres_q <= set_thres_d;
         busy_q      <= busy_d;
         all_idle_q  <= all_idle_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign new_thres = new_thres_q;
   assign sel_thres = sel_thres_q;
   assign set_thres = set_thres_q;
   assign busy      = busy_q;
   assign all_idle  = all_idle_q;
   assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: directed scenarios plus random config/tick traffic
// checked against a per-period channel model.
module tb_pwm_fade_ctrl;

   localparam int PW = 16;
   localparam int N  = 4;
   localparam int SW = 8;
   localparam int CW = 2;
   localparam int VW = 1 + CW + PW + N + 1;

   typedef logic [VW-1:0] vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_chan;
   logic [PW-1:0] cfg_target;
   logic [SW-1:0] cfg_step;
   logic          period_tick;
   logic [PW-1:0] new_thres;
   logic [CW-1:0] sel_thres;
   logic          set_thres;
   logic [N-1:0]  busy;
   logic          all_idle;

   always #5 clk = ~clk;

   pwm_fade_ctrl #(.PWM_WIDTH(PW), .NUM_PWM(N), .STEP_WIDTH(SW)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
      .cfg_target(cfg_target), .cfg_step(cfg_step),
      .period_tick(period_tick),
      .new_thres(new_thres), .sel_thres(sel_thres), .set_thres(set_thres),
      .busy(busy), .all_idle(all_idle)
   );

   vec_t dut_vec;
   assign dut_vec = {set_thres, sel_thres, new_thres, busy, all_idle};

   int n_checks = 0;
   int n_fail   = 0;
   logic pick_ready;

   // Channel-level model: what each period should write.
   int mcur [N];
   int mtgt [N];
   int mstep[N];
   int mptr;
   int e_new, e_sel;
   bit e_set;

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin mcur[c] = 0; mtgt[c] = 0; mstep[c] = 0; end
      mptr = N - 1; e_new = 0; e_sel = 0; e_set = 0;
   endtask

   task automatic model_tick();
      int c, nxt;
      e_set = 0;
      for (int k = 1; k <= N; k++) begin
         c = (mptr + k) % N;
         if (!e_set && mcur[c] != mtgt[c]) begin
            if (mstep[c] == 0) nxt = mtgt[c];
            else if (mcur[c] < mtgt[c]) nxt = (mcur[c] + mstep[c] > mtgt[c]) ? mtgt[c] : mcur[c] + mstep[c];
            else nxt = (mcur[c] - mstep[c] < mtgt[c]) ? mtgt[c] : mcur[c] - mstep[c];
            mcur[c] = nxt; e_new = nxt; e_sel = c; e_set = 1; mptr = c;
         end
      end
   endtask

   function automatic vec_t exp_vec();
      logic [N-1:0] b;
      for (int c = 0; c < N; c++) b[c] = mcur[c] != mtgt[c];
      return {e_set, CW'(e_sel), PW'(e_new), b, ~|b};
   endfunction

   // Pulse period_tick; returns once the resulting write is visible.
   task automatic tick();
      period_tick = 1'b1;
      @(posedge clk); #1;
      period_tick = 1'b0;
      pick_ready  = cfg_ready;
      @(posedge clk); #1;
      model_tick();
   endtask

   task automatic cfg_write(input int ch, input int tg, input int st);
      int t = 0;
      while (cfg_ready !== 1'b1 && t < 8) begin @(posedge clk); #1; t++; end
      if (cfg_ready !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL cfg_ready_timeout: cfg_ready=%b required 1", cfg_ready);
      end
      cfg_valid = 1'b1; cfg_chan = CW'(ch); cfg_target = PW'(tg); cfg_step = SW'(st);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      mtgt[ch] = tg; mstep[ch] = st;
   endtask

   task automatic test_reset();
      vec_t rv;
      rv = {1'b0, CW'(0), PW'(0), N'(0), 1'b1};
      n_checks++;
      if (dut_vec !== rv) begin n_fail++; $display("FAIL reset_outputs: got %h required %h", dut_vec, rv); end
      n_checks++;
      if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_ready: got %b required 0", cfg_ready); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_ready_after_reset: got %b required 1", cfg_ready); end
      cfg_write(2, 'h500, 'h10);
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL pre_reset_write%0d: got %h required %h", i, dut_vec, exp_vec()); end
      end
      @(negedge clk); rst = 1'b1; #1;
      model_reset();
      n_checks++;
      if (dut_vec !== rv) begin n_fail++; $display("FAIL async_reset_hold: got %h required %h", dut_vec, rv); end
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (dut_vec !== rv) begin n_fail++; $display("FAIL post_reset_tick%0d: got %h required %h", i, dut_vec, rv); end
      end
   endtask

   task automatic test_upward_fade();
      int exp_w[4] = '{'h0040, 'h0080, 'h00C0, 'h0100};
      cfg_write(1, 'h0100, 'h40);
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec() || new_thres !== PW'(exp_w[i]) || sel_thres !== CW'(1)) begin
            n_fail++; $display("FAIL up_fade_step%0d: got %h required new=%h model %h", i, dut_vec, exp_w[i], exp_vec());
         end
         repeat (3) @(posedge clk); #1;
         n_checks++;
         if (set_thres !== 1'b1 || new_thres !== PW'(exp_w[i])) begin
            n_fail++; $display("FAIL up_fade_hold%0d: set=%b new=%h required 1 %h", i, set_thres, new_thres, exp_w[i]);
         end
      end
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || set_thres !== 1'b0 || busy !== '0) begin
         n_fail++; $display("FAIL up_fade_done: got %h required %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_jump_saturation();
      int writes = 0;
      logic [PW-1:0] last = '0;
      cfg_write(2, 'h1234, 0);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || new_thres !== 16'h1234) begin
         n_fail++; $display("FAIL jump_write: got %h required new=1234 model %h", dut_vec, exp_vec());
      end
      tick();
      cfg_write(2, 'hFFFF, 'hFF);
      for (int i = 0; i < 300 && (writes == 0 || e_set); i++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL sat_step%0d: got %h required %h", i, dut_vec, exp_vec()); end
         if (e_set) begin
            if (writes == 0) begin
               n_checks++;
               if (new_thres !== 16'h1333) begin n_fail++; $display("FAIL sat_first: got %h required 1333", new_thres); end
            end
            writes++; last = new_thres;
         end
      end
      n_checks++;
      if (last !== 16'hFFFF || e_set) begin n_fail++; $display("FAIL sat_final: got %h required ffff", last); end
   endtask

   task automatic test_downward_clamp();
      cfg_write(0, 'h0100, 0);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL down_setup: got %h required %h", dut_vec, exp_vec()); end
      cfg_write(0, 'h00F0, 'h40);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || new_thres !== 16'h00F0 || busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL down_clamp: got %h required new=00f0 model %h", dut_vec, exp_vec());
      end
      tick();
      n_checks++;
      if (set_thres !== 1'b0) begin n_fail++; $display("FAIL down_idle: set=%b required 0", set_thres); end
   endtask

   task automatic test_round_robin();
      int writes = 0;
      int prev = -1;
      cfg_write(0, 'h00F3, 1);
      cfg_write(3, 'h0003, 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL rr_step%0d: got %h required %h", i, dut_vec, exp_vec()); end
         if (set_thres === 1'b1) begin
            n_checks++;
            if (int'(sel_thres) == prev) begin n_fail++; $display("FAIL rr_alternate%0d: sel=%0d repeated", i, sel_thres); end
            prev = int'(sel_thres); writes++;
         end
      end
      n_checks++;
      if (writes != 6) begin n_fail++; $display("FAIL rr_count: got %0d required 6", writes); end
   endtask

   task automatic test_retarget_hold();
      int exp_w[2] = '{'h0040, 'h0000};
      cfg_write(1, 'h0080, 0);
      tick();
      n_checks++;
      if (dut_vec !== exp_vec() || new_thres !== 16'h0080) begin n_fail++; $display("FAIL rt_setup: got %h required %h", dut_vec, exp_vec()); end
      cfg_write(1, 'h0000, 'h40);
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if ({set_thres, sel_thres, new_thres} !== {1'b1, CW'(1), 16'h0080} || cfg_ready !== 1'b1) begin
         n_fail++; $display("FAIL rt_held: got %b %h %h rdy=%b required 1 1 0080 1", set_thres, sel_thres, new_thres, cfg_ready);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec() || new_thres !== PW'(exp_w[i]) || pick_ready !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL rt_step%0d: got %h pick_rdy=%b required new=%h model %h", i, dut_vec, pick_ready, exp_w[i], exp_vec());
         end
      end
   endtask

   task automatic test_random();
      int st;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            st = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(128, 255));
            cfg_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 16'hFFFF)), st);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL rand_step%0d: got %h required %h", i, dut_vec, exp_vec()); end
      end
      for (int i = 0; i < 3000 && e_set; i++) begin
         tick();
         n_checks++;
         if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL rand_drain%0d: got %h required %h", i, dut_vec, exp_vec()); end
      end
      n_checks++;
      if (all_idle !== 1'b1 || e_set) begin n_fail++; $display("FAIL rand_drain_idle: all_idle=%b required 1", all_idle); end
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_target = '0; cfg_step = '0;
      period_tick = 1'b0; pick_ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      test_reset();
      test_upward_fade();
      test_jump_saturation();
      test_downward_clamp();
      test_round_robin();
      test_retarget_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
